// File: rtl/text_console_writer_pkg.sv
// text_console_writer_pkg: shared geometry defaults, control codes and FSM state type.
package text_console_writer_pkg;

    localparam int COLS_DEF   = 80;
    localparam int ROWS_DEF   = 60;
    localparam int ADDR_W_DEF = 13;

    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] BS    = 8'h08;
    localparam logic [7:0] FF    = 8'h0C;

    typedef enum logic [1:0] {IDLE, PUT, ROWCLR, CLEAR} state_t;

endpackage

// File: rtl/text_console_writer_if.sv
// text_console_if: character stream in, text-RAM write port and cursor out.
interface text_console_if
    import text_console_writer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);

    logic [7:0]        chr_i;
    logic              chr_valid_i;
    logic              chr_ready_o;
    logic              clear_i;
    logic              busy_o;
    logic              ram_we_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [7:0]        ram_data_o;
    logic [6:0]        cur_col_o;
    logic [5:0]        cur_row_o;

    modport slave (
        input  chr_i, chr_valid_i, clear_i,
        output chr_ready_o, busy_o, ram_we_o, ram_addr_o, ram_data_o, cur_col_o, cur_row_o
    );

    modport master (
        output chr_i, chr_valid_i, clear_i,
        input  chr_ready_o, busy_o, ram_we_o, ram_addr_o, ram_data_o, cur_col_o, cur_row_o
    );

endinterface

// File: rtl/text_console_writer_cursor.sv
// console_cursor: column/row counters plus a running row*COLS base, giving the linear address without a multiplier.
module console_cursor #(
    parameter int COLS   = 80,
    parameter int ROWS   = 60,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advance,
    input  logic              newline,
    input  logic              ret,
    input  logic              back,
    input  logic              home,
    output logic [6:0]        col,
    output logic [5:0]        row,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] base;
    logic              row_end;
    logic              line;

    assign row_end = row == 6'(ROWS - 1);
    assign line    = newline || (advance && col == 7'(COLS - 1));
    assign addr    = base + ADDR_W'(col);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col  <= '0;
            row  <= '0;
            base <= '0;
        end else if (home) begin
            col  <= '0;
            row  <= '0;
            base <= '0;
        end else if (line) begin
            col  <= '0;
            row  <= row_end ? '0 : row + 6'd1;
            base <= row_end ? '0 : base + ADDR_W'(COLS);
        end else if (advance) begin
            col <= col + 7'd1;
        end else if (ret) begin
            col <= '0;
        end else if (back) begin
            col <= col - 7'd1;
        end
    end

endmodule

// File: rtl/text_console_writer.sv
// text_console_writer: streams characters into a COLS x ROWS text RAM with cursor control,
// automatic clearing of each freshly entered row and full-screen clear.
module text_console_writer
    import text_console_writer_pkg::*;
#(
    parameter int COLS   = COLS_DEF,
    parameter int ROWS   = ROWS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input logic           clk_i,
    input logic           rst_n_i,
    text_console_if.slave bus
);

    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(ROWS * COLS - 1);
    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(COLS - 1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] cnt, cnt_n, cur_addr, addr_n;
    logic [7:0]        data_n;
    logic [6:0]        col;
    logic [5:0]        row;
    logic              fin, fin_n, we_n, take, at_end;
    logic              advance, newline, ret, back, home;

    assign bus.chr_ready_o = state == IDLE && !bus.clear_i;
    assign bus.busy_o      = state == ROWCLR || state == CLEAR;
    assign bus.cur_col_o   = col;
    assign bus.cur_row_o   = row;
    assign take            = bus.chr_ready_o && bus.chr_valid_i;
    assign at_end          = col == 7'(COLS - 1);

    console_cursor #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_cursor (
        .clk     (clk_i),
        .rst_n   (rst_n_i),
        .advance (advance),
        .newline (newline),
        .ret     (ret),
        .back    (back),
        .home    (home),
        .col     (col),
        .row     (row),
        .addr    (cur_addr)
    );

    // Clear states hold the write under way in the output register; fin marks that the last one is showing.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        fin_n   = fin;
        we_n    = 1'b0;
        addr_n  = bus.ram_addr_o;
        data_n  = bus.ram_data_o;
        advance = 1'b0;
        newline = 1'b0;
        ret     = 1'b0;
        back    = 1'b0;
        home    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.clear_i || (take && bus.chr_i == FF)) begin
                    state_n = CLEAR;
                    cnt_n   = '0;
                    fin_n   = 1'b0;
                end else if (take && bus.chr_i >= SPACE) begin
                    we_n    = 1'b1;
                    addr_n  = cur_addr;
                    data_n  = bus.chr_i;
                    advance = 1'b1;
                    state_n = at_end ? ROWCLR : IDLE;
                    cnt_n   = '0;
                    fin_n   = 1'b0;
                end else if (take && bus.chr_i == LF) begin
                    newline = 1'b1;
                    state_n = ROWCLR;
                    cnt_n   = '0;
                    fin_n   = 1'b0;
                end else if (take && bus.chr_i == CR) begin
                    ret = 1'b1;
                end else if (take && bus.chr_i == BS && col != 7'd0) begin
                    back    = 1'b1;
                    state_n = PUT;
                end
            end
            PUT: begin
                we_n    = 1'b1;
                addr_n  = cur_addr;
                data_n  = SPACE;
                state_n = IDLE;
            end
            ROWCLR: begin
                if (fin) begin
                    state_n = IDLE;
                end else begin
                    we_n   = 1'b1;
                    addr_n = cur_addr + cnt;
                    data_n = SPACE;
                    fin_n  = cnt == COL_LAST;
                    cnt_n  = fin_n ? cnt : cnt + ADDR_W'(1);
                end
            end
            CLEAR: begin
                if (fin) begin
                    state_n = IDLE;
                    home    = 1'b1;
                end else begin
                    we_n   = 1'b1;
                    addr_n = cnt;
                    data_n = SPACE;
                    fin_n  = cnt == LAST;
                    cnt_n  = fin_n ? cnt : cnt + ADDR_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            state <= CLEAR;
        else
            state <= state_n;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt            <= '0;
            fin            <= 1'b0;
            bus.ram_we_o   <= 1'b0;
            bus.ram_addr_o <= '0;
            bus.ram_data_o <= '0;
        end else begin
            cnt            <= cnt_n;
            fin            <= fin_n;
            bus.ram_we_o   <= we_n;
            bus.ram_addr_o <= addr_n;
            bus.ram_data_o <= data_n;
        end
    end

endmodule
